// File: rtl/axi_master_drain.sv
`default_nettype none
// ============================================================================
// Module   : axi_master_drain
// Purpose  : Interrupt-driven AXI4 master. It reads a status word, drains two
//            slave FIFOs as bursts towards a pixel sink, then writes the
//            status word back to the slave.
// Option   : `define AXI_MASTER_DRAIN_ERR_EN enables the sticky o_err monitor.
// Revision : 1.0 - initial release
// ============================================================================
module axi_master_drain #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h000F_0000),
  parameter logic [3:0]            BURST_LEN  = 4'd15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_interrupt,
  // AR channel
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [3:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic [ID_WIDTH-1:0]   o_arid,
  // R channel
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic [ID_WIDTH-1:0]   i_rid,
  // AW channel
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [3:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic [ID_WIDTH-1:0]   o_awid,
  // W channel
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [3:0]            o_wstrb,
  output logic                  o_wlast,
  // B channel
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  input  logic [ID_WIDTH-1:0]   i_bid,
  // Pixel sink
  output logic                  o_pix_valid,
  output logic [15:0]           o_pix_data,
  output logic                  o_pix_sel,
  input  logic                  i_pix_ready,
  // Status
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] ST_AR  = 4'd1;
  localparam logic [3:0] ST_R   = 4'd2;
  localparam logic [3:0] F1_AR  = 4'd3;
  localparam logic [3:0] F1_R   = 4'd4;
  localparam logic [3:0] F2_AR  = 4'd5;
  localparam logic [3:0] F2_R   = 4'd6;
  localparam logic [3:0] WR_AWW = 4'd7;
  localparam logic [3:0] WR_B   = 4'd8;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_F1 = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_F2 = BASE_ADDR + ADDR_WIDTH'(8);

  logic [3:0]            r_state;
  logic [3:0]            w_next;
  logic [3:0]            r_beat;
  logic [DATA_WIDTH-1:0] r_status;
  logic                  r_aw_done;
  logic                  r_w_done;

  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_fifo_r;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_rlast_hs;

  assign w_fifo_r   = (r_state == F1_R) || (r_state == F2_R);
  assign w_r_hs     = i_rvalid && o_rready;
  assign w_rlast_hs = w_r_hs && i_rlast;
  assign w_aw_hs    = o_awvalid && i_awready;
  assign w_w_hs     = o_wvalid && i_wready;
  assign w_aw_fin   = r_aw_done || w_aw_hs;
  assign w_w_fin    = r_w_done || w_w_hs;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (i_enable && i_interrupt) w_next = ST_AR;
      ST_AR:  if (i_arready) w_next = ST_R;
      ST_R:   if (w_rlast_hs) w_next = i_rdata[0] ? F1_AR : IDLE;
      F1_AR:  if (i_arready) w_next = F1_R;
      F1_R:   if (w_rlast_hs) w_next = F2_AR;
      F2_AR:  if (i_arready) w_next = F2_R;
      F2_R:   if (w_rlast_hs) w_next = WR_AWW;
      WR_AWW: if (w_aw_fin && w_w_fin) w_next = WR_B;
      WR_B:   if (i_bvalid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_beat    <= 4'd0;
      r_status  <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;

      if ((r_state == F1_AR) || (r_state == F2_AR))
        r_beat <= 4'd0;
      else if (w_fifo_r && w_r_hs)
        r_beat <= r_beat + 4'd1;

      if ((r_state == ST_R) && w_rlast_hs)
        r_status <= i_rdata;

      // Completion flags live only while both handshakes are still pending.
      if ((r_state == WR_AWW) && !(w_aw_fin && w_w_fin)) begin
        r_aw_done <= w_aw_fin;
        r_w_done  <= w_w_fin;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    o_araddr = BASE_ADDR;
    case (r_state)
      F1_AR:   o_araddr = c_ADDR_F1;
      F2_AR:   o_araddr = c_ADDR_F2;
      default: o_araddr = BASE_ADDR;
    endcase
  end

  assign o_arvalid = (r_state == ST_AR) || (r_state == F1_AR) || (r_state == F2_AR);
  assign o_arlen   = (r_state == ST_AR) ? 4'd0 : BURST_LEN;
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_arid    = '0;

  assign o_rready    = (r_state == ST_R) || (w_fifo_r && i_pix_ready);
  assign o_pix_valid = w_fifo_r && i_rvalid;
  assign o_pix_data  = i_rdata[15:0];
  assign o_pix_sel   = (r_state == F2_R);

  assign o_awvalid = (r_state == WR_AWW) && !r_aw_done;
  assign o_awaddr  = BASE_ADDR;
  assign o_awlen   = 4'd0;
  assign o_awsize  = 3'b010;
  assign o_awburst = 2'b01;
  assign o_awid    = '0;

  assign o_wvalid = (r_state == WR_AWW) && !r_w_done;
  assign o_wdata  = r_status;
  assign o_wstrb  = 4'hF;
  assign o_wlast  = o_wvalid;

  assign o_bready = (r_state == WR_B);
  assign o_busy   = (r_state != IDLE);

`ifdef AXI_MASTER_DRAIN_ERR_EN
  logic r_err;
  logic w_err_hit;
  logic w_unused;

  // A short burst is detected on its last beat, before the counter advances.
  assign w_err_hit = (w_r_hs && (i_rresp != 2'b00))
                  || ((o_bready && i_bvalid) && (i_bresp != 2'b00))
                  || (w_fifo_r && w_rlast_hs && (r_beat != BURST_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_err_hit)
      r_err <= 1'b1;
  end

  assign o_err    = r_err;
  assign w_unused = ^{i_rid, i_bid};
`else
  logic w_unused;
  assign o_err    = 1'b0;
  assign w_unused = ^{i_rid, i_bid, i_rresp, i_bresp, r_beat};
`endif

endmodule
`default_nettype wire
